// File: rtl/timestamp_reader_pkg.sv
// Shared types and constants for the timestamp frame reader.
package timestamp_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP0,
        ST_SNAP1,
        ST_SEND,
        ST_ACK
    } state_t;

    localparam int         FRAME_LEN = 14;
    localparam logic [7:0] HDR_FLAG  = 8'h10;

    // Byte positions inside the frame.
    localparam logic [3:0] IDX_HDR = 4'd0;
    localparam logic [3:0] IDX_LO  = 4'd1;
    localparam logic [3:0] IDX_HI  = 4'd5;
    localparam logic [3:0] IDX_PH  = 4'd9;
    localparam logic [3:0] IDX_CS  = 4'd13;

    typedef struct packed {
        logic [31:0] phase;
        logic [31:0] hi;
        logic [31:0] lo;
    } snap_t;

    // Picks byte idx (0..12) out of the 13-byte frame image: header,
    // then lo, hi, phase, each little-endian.
    function automatic logic [7:0] frame_byte(snap_t s, logic [7:0] hdr, logic [3:0] idx);
        logic [103:0] img;
        img = {s.phase, s.hi, s.lo, hdr} >> {idx, 3'b000};
        return img[7:0];
    endfunction

endpackage

// File: rtl/timestamp_reader_if.sv
// Valid/ready byte stream from the reader toward the USB FIFO.
interface timestamp_reader_if;
    logic [7:0] oByte;
    logic       oByteValid;
    logic       iByteReady;

    modport master (output oByte, output oByteValid, input iByteReady);
    modport slave  (input oByte, input oByteValid, output iByteReady);
endinterface

// File: rtl/timestamp_reader_rdy_sync.sv
// N-stage single-bit synchronizer for the asynchronous latch-ready flags.
// N must be at least 2.
module rdy_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] stages;

    // Shift the raw flag through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) stages <= '0;
        else     stages <= {stages[N-2:0], d};
    end

    assign q = stages[N-1];
endmodule

// File: rtl/timestamp_reader.sv
// Takes a consistent snapshot of a ready channel's latched count/phase,
// sends it as a 14-byte checksummed frame and releases the latch.
//
// state | meaning
// IDLE  | waiting for an eligible channel
// SNAP0 | first capture of {phase, hi, lo}
// SNAP1 | second capture, compared against the first
// SEND  | streaming the frame bytes
// ACK   | one-cycle latch release pulse for the served channel
module timestamp_reader
    import timestamp_reader_pkg::*;
#(
    parameter int         pSYNC_STAGES = 2,
    parameter int         pMAX_RETRY   = 4,
    parameter logic [7:0] pHDR1        = 8'hA1
) (
    input  logic        globalClock,
    input  logic        iReset,
    input  logic        iRdyCOUNTER,
    input  logic        iRdyCOUNTER2,
    input  logic [31:0] i1COUNTER,
    input  logic [31:0] i1COUNTERHi,
    input  logic [31:0] i1COUNTERPhase,
    input  logic [31:0] i2COUNTER,
    input  logic [31:0] i2COUNTERHi,
    input  logic [31:0] i2COUNTERPhase,
    output logic        oResetLatch1,
    output logic        oResetLatch2,
    output logic        oBusy,
    output logic [7:0]  oRetryCount,
    timestamp_reader_if.master stream
);
    localparam logic [7:0] MAX_RETRY = 8'(pMAX_RETRY);
    localparam logic [7:0] HDR2      = pHDR1 + 8'd1;

    state_t     state, state_nx;
    logic       r1, r2;
    logic [1:0] armed;
    logic       last_ch2;
    logic       sel_ch2, sel_ch2_nx;
    logic       flagged, flagged_nx;
    logic [7:0] retries, retries_nx;
    logic       retry_inc, ack;
    logic       elig1, elig2;
    snap_t      live, snap_a, snap_b;
    logic [3:0] idx;
    logic [7:0] csum, hdr, cur_byte, retry_cnt;

    rdy_sync #(.N(pSYNC_STAGES)) u_sync1 (.clk(globalClock), .rst(iReset), .d(iRdyCOUNTER),  .q(r1));
    rdy_sync #(.N(pSYNC_STAGES)) u_sync2 (.clk(globalClock), .rst(iReset), .d(iRdyCOUNTER2), .q(r2));

    // armed blocks re-serving a flag that never dropped after its release.
    assign elig1 = r1 && armed[0];
    assign elig2 = r2 && armed[1];
    assign live  = sel_ch2 ? {i2COUNTERPhase, i2COUNTERHi, i2COUNTER}
                           : {i1COUNTERPhase, i1COUNTERHi, i1COUNTER};

    // State and per-frame control registers.
    always_ff @(posedge globalClock) begin
        if (iReset) begin
            state   <= ST_IDLE;
            sel_ch2 <= 1'b0;
            flagged <= 1'b0;
            retries <= '0;
        end else begin
            state   <= state_nx;
            sel_ch2 <= sel_ch2_nx;
            flagged <= flagged_nx;
            retries <= retries_nx;
        end
    end

    // Next-state logic, channel arbitration and snapshot comparison.
    always_comb begin
        state_nx   = state;
        sel_ch2_nx = sel_ch2;
        flagged_nx = flagged;
        retries_nx = retries;
        retry_inc  = 1'b0;
        ack        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (elig1 || elig2) begin
                    // With both eligible, take the one not served last.
                    sel_ch2_nx = elig2 && (!elig1 || !last_ch2);
                    retries_nx = '0;
                    flagged_nx = 1'b0;
                    state_nx   = ST_SNAP0;
                end
            end
            ST_SNAP0: state_nx = ST_SNAP1;
            ST_SNAP1: begin
                if (live == snap_a) begin
                    state_nx = ST_SEND;
                end else if (retries < MAX_RETRY) begin
                    retries_nx = retries + 8'd1;
                    retry_inc  = 1'b1;
                    state_nx   = ST_SNAP0;
                end else begin
                    flagged_nx = 1'b1;
                    state_nx   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (stream.iByteReady && idx == IDX_CS) state_nx = ST_ACK;
            end
            ST_ACK: begin
                ack      = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Snapshot capture, byte index, running checksum, arming and statistics.
    always_ff @(posedge globalClock) begin
        if (iReset) begin
            snap_a    <= '0;
            snap_b    <= '0;
            idx       <= '0;
            csum      <= '0;
            retry_cnt <= '0;
            armed     <= 2'b11;
            last_ch2  <= 1'b1;
        end else begin
            if (state == ST_SNAP0) snap_a <= live;
            if (state == ST_SNAP1) begin
                snap_b <= live;
                idx    <= '0;
                csum   <= '0;
            end else if (state == ST_SEND && stream.iByteReady) begin
                idx  <= idx + 4'd1;
                csum <= csum ^ cur_byte;
            end
            if (retry_inc && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
            if (ack) begin
                armed[sel_ch2] <= 1'b0;
                last_ch2       <= sel_ch2;
            end
            // A dropped flag re-arms its channel, even in the ACK cycle.
            if (!r1) armed[0] <= 1'b1;
            if (!r2) armed[1] <= 1'b1;
        end
    end

    assign hdr      = (sel_ch2 ? HDR2 : pHDR1) | (flagged ? HDR_FLAG : 8'h00);
    assign cur_byte = (idx == IDX_CS) ? csum : frame_byte(snap_b, hdr, idx);

    assign stream.oByte      = (state == ST_SEND) ? cur_byte : 8'h00;
    assign stream.oByteValid = (state == ST_SEND);
    assign oResetLatch1      = ack && !sel_ch2;
    assign oResetLatch2      = ack && sel_ch2;
    assign oBusy             = (state != ST_IDLE);
    assign oRetryCount       = retry_cnt;
endmodule
